frame_loader: RTL and testbench
===============================

# frame_loader

Byte-stream-to-framebuffer loader for the LED matrix display path. It sits between `spi_slave` (data/valid/sot/eot byte stream) and the double-buffered `display_memory`. It assembles bytes into pixels, writes them row-major into the back buffer and requests a buffer flip only at a `display_driver` frame boundary. It is the parametrised successor of the hard-wired 2-byte, 8x32 load logic: pixel size, geometry and pixel format are configurable, and it adds frame-length checking and error flags.

## Interface

Parameters:

- `rows`, 8: display rows per segment, ≥2.
- `columns`, 32: display columns, ≥2.
- `width`, 24: memory word width; must be ≥ 8*`bytes_per_pixel` in raw format.
- `bytes_per_pixel`, 2: bytes per pixel, 1..3.
- `format`, FMT_RGB565: FMT_RAW (bytes concatenated MSB-first, zero-extended to `width`) or FMT_RGB565 (requires `bytes_per_pixel`=2, `width`=24).

Ports:

- `clk`, in, 1: single clock (display clock domain).
- `rst`, in, 1: reset, synchronous, active-low.
- `data`, in, 8: stream byte.
- `valid`, in, 1: `data` is valid this cycle.
- `sot`, in, 1: qualifies the first byte of a frame (only meaningful with `valid`).
- `eot`, in, 1: end-of-frame strobe, independent of `valid`.
- `frame_complete`, in, 1: driver finished scanning a frame.
- `wen`, out, 1: memory write enable, one cycle per pixel.
- `wrow`, out, $clog2(rows): write row.
- `wcol`, out, $clog2(columns): write column.
- `wdata`, out, `width`: pixel word.
- `flip`, out, 1: buffer-select level; toggles once per accepted frame.
- `busy`, out, 1: high in LOAD and WAIT_FLIP.
- `frame_done`, out, 1: one-cycle pulse on the cycle `flip` toggles.
- `err_short`, out, 1: sticky; eot arrived before rows*columns pixels.
- `err_overrun`, out, 1: sticky; a byte arrived after the frame was full.

## Operation

- Reset (`rst`=0 at a clock edge) forces all outputs to 0 and the state to IDLE. Byte counter, address and accumulator are cleared. A reset mid-frame abandons the frame with no flip.
- States are IDLE, LOAD and WAIT_FLIP.
- **IDLE.** Bytes without `sot` are dropped. `valid`&`sot` clears both error flags, clears the address to (0,0) and accepts that byte as the first pixel byte. The state goes to LOAD.
- **LOAD, byte handling.**
  - Each `valid` byte shifts into the accumulator.
  - On byte `bytes_per_pixel`, a pixel is written to the current (row, col). The column then advances; at `columns`-1 it wraps to 0 and the row increments.
  - When a `valid` byte arrives after rows*columns pixels have been written, the byte is dropped and `err_overrun` is set.
- **LOAD, restart.** `valid`&`sot` restarts the frame: address goes to (0,0), any partial pixel is discarded, and the byte becomes byte 1.
- **LOAD, eot.**
  - Ordering in one cycle: a `valid` byte is consumed first, then `eot` is evaluated.
  - Pixel count = rows*columns → WAIT_FLIP. A trailing partial pixel is not an error and is discarded.
  - Fewer pixels → set `err_short`, go to IDLE, no flip.
- **WAIT_FLIP.** All bytes are ignored, including `sot`, and no errors are flagged. `frame_complete`=1 toggles `flip`, pulses `frame_done` and returns to IDLE.
- **frame_complete in LOAD.** A `frame_complete` in the same cycle as the accepting `eot` does not flip; the flip waits for the next `frame_complete`.
- **FMT_RGB565 packing.** The first byte is the high byte of word w. Bit fields are R = w[15:11], G = w[10:5], B = w[4:0].
  - wdata[7:0] = {R, R[4:2]}
  - wdata[15:8] = {G, G[5:4]}
  - wdata[23:16] = {B, B[4:2]}
- **FMT_RAW packing.** wdata = zero-extended {byte1, …, byteN}.

## Timing

- `wen`, `wrow`, `wcol` and `wdata` are registered. They are valid in the cycle after the last byte of a pixel is accepted.
- Back-to-back `valid` every cycle is supported with no stall.
- `flip` and `frame_done` change in the cycle after `frame_complete` is sampled high in WAIT_FLIP.
- `busy` rises the cycle after the accepting `sot` and falls with `frame_done`, or the cycle after a short `eot`.
- Error flags assert the cycle after the offending event and hold until reset or the next accepted `sot`.

## Structure

- Shared package `display_pkg` holds:
  - FMT_RAW and FMT_RGB565 constants;
  - the state enum;
  - the `rgb565_to_888` expansion function.
- Sub-module `pixel_assembler` holds the byte counter, the accumulator and format conversion. It outputs pixel word plus a `pixel_valid` pulse.
- `frame_loader` owns the FSM, address counters and flags.

## Test plan

- **Full frame.** Defaults; sot, then 512 bytes of 0xF8,0x00 repeated, then eot; pulse `frame_complete` 10 cycles later. Expect 256 `wen` pulses, each wdata=0x0000FF, last write (7,31). `flip` 0→1 with `frame_done` one cycle after `frame_complete`.
- **Short frame.** eot after 100 bytes. Expect 50 writes, `err_short`=1, `flip` unchanged, `busy`=0 the next cycle.
- **Overrun.** 514 bytes before eot. Expect 256 writes, `err_overrun`=1, and the frame still flips on `frame_complete`.
- **Mid-frame restart.** sot after 7 bytes. Expect 3 writes to (0,0..2), then a fresh frame starting at (0,0). The dropped odd byte must not corrupt the pixel.
- **Boundary timing.** `frame_complete` in the same cycle as the final eot → no flip until the next `frame_complete`. Reset asserted in WAIT_FLIP → `flip`=0, `busy`=0, and a later `frame_complete` has no effect.
- **Raw format.** FMT_RAW, `bytes_per_pixel`=3, rows=4, columns=4; 48 bytes 0x01..0x30. Expect first wdata=0x010203 at (0,0) and last wdata=0x2E2F30 at (3,3).

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the LED matrix display path.
//   FMT_RAW / FMT_RGB565 : pixel format selectors for frame_loader/pixel_assembler
//   load_state_t         : frame_loader FSM states
//   rgb565_to_888        : expands a 5-6-5 word into the 24-bit memory layout
package display_pkg;

  localparam int unsigned FMT_RAW    = 0;
  localparam int unsigned FMT_RGB565 = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_FLIP = 2'd2
  } load_state_t;

  // Memory layout is {B, G, R}; each channel is widened by replicating its MSBs
  // into the vacated LSBs so that full-scale stays full-scale.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
    return {w[4:0], w[4:2], w[10:5], w[10:9], w[15:11], w[15:13]};
  endfunction

endpackage

// File: rtl/pixel_assembler.sv
// Collects stream bytes into one pixel and converts it to the memory word.
//   clk, rst     : clock, synchronous active-low reset
//   accept       : the byte on data is consumed this cycle
//   start        : this byte is byte 1 of a pixel (any partial pixel is dropped)
//   clear        : discard a partial pixel at the end of this cycle
//   data         : stream byte
//   pixel_valid  : combinational; the accepted byte completes a pixel
//   pixel        : combinational pixel word, meaningful with pixel_valid
module pixel_assembler
  import display_pkg::*;
#(
  parameter int unsigned width           = 24,
  parameter int unsigned bytes_per_pixel = 2,
  parameter int unsigned format          = FMT_RGB565
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             start,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic             pixel_valid,
  output logic [width-1:0] pixel
);

  localparam int unsigned AW   = 8 * bytes_per_pixel;
  localparam logic [1:0]  LAST = 2'(bytes_per_pixel - 1);

  logic [1:0]    cnt, base_cnt;
  logic [AW-1:0] acc, base_acc, word;

  // The completed word includes the byte arriving this cycle, so a pixel is
  // available without waiting for the accumulator to update.
  always_comb begin
    base_cnt    = start ? '0 : cnt;
    base_acc    = start ? '0 : acc;
    word        = AW'({base_acc, data});
    pixel_valid = accept && (base_cnt == LAST);
  end

  if (format == FMT_RGB565) begin : g_rgb565
    assign pixel = width'(rgb565_to_888(word[15:0]));
  end else begin : g_raw
    assign pixel = width'(word);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (accept) begin
      if (pixel_valid) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= base_cnt + 2'd1;
        acc <= word;
      end
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Byte-stream to framebuffer loader: assembles pixels, writes them row-major
// into the back buffer and flips buffers on a driver frame boundary.
//   clk, rst                 : clock, synchronous active-low reset
//   data, valid, sot, eot    : byte stream from spi_slave
//   frame_complete           : display_driver finished scanning a frame
//   wen, wrow, wcol, wdata   : registered memory write port
//   flip                     : buffer select, toggles once per accepted frame
//   busy                     : frame in progress or waiting for flip
//   frame_done               : one-cycle pulse when flip toggles
//   err_short, err_overrun   : sticky frame-length errors, cleared by sot
module frame_loader
  import display_pkg::*;
#(
  parameter int unsigned rows            = 8,
  parameter int unsigned columns         = 32,
  parameter int unsigned width           = 24,
  parameter int unsigned bytes_per_pixel = 2,
  parameter int unsigned format          = FMT_RGB565
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data,
  input  logic                       valid,
  input  logic                       sot,
  input  logic                       eot,
  input  logic                       frame_complete,
  output logic                       wen,
  output logic [$clog2(rows)-1:0]    wrow,
  output logic [$clog2(columns)-1:0] wcol,
  output logic [width-1:0]           wdata,
  output logic                       flip,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err_short,
  output logic                       err_overrun
);

  localparam int unsigned RW = $clog2(rows);
  localparam int unsigned CW = $clog2(columns);
  localparam logic [RW-1:0] ROW_LAST = RW'(rows - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(columns - 1);

  load_state_t   state, state_next;
  logic [RW-1:0] row, row_base, row_next;
  logic [CW-1:0] col, col_base, col_next;
  logic          full, full_base, full_next;
  logic          accept, start, clr_flags, set_over, set_short, do_flip;
  logic          pix_valid;
  logic [width-1:0] pix;

  pixel_assembler #(
    .width           (width),
    .bytes_per_pixel (bytes_per_pixel),
    .format          (format)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .accept      (accept),
    .start       (start),
    .clear       (state_next != ST_LOAD),
    .data        (data),
    .pixel_valid (pix_valid),
    .pixel       (pix)
  );

  // Byte decode is kept apart from the next-state logic: the eot decision
  // depends on whether this cycle's byte completes the frame, which comes
  // back through the assembler.
  always_comb begin
    accept    = 1'b0;
    start     = 1'b0;
    clr_flags = 1'b0;
    set_over  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (valid && sot) begin
          accept    = 1'b1;
          start     = 1'b1;
          clr_flags = 1'b1;
        end
      end
      ST_LOAD: begin
        if (valid) begin
          if (sot) begin
            accept    = 1'b1;
            start     = 1'b1;
            clr_flags = 1'b1;
          end else if (full) begin
            set_over = 1'b1;
          end else begin
            accept = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    row_base  = start ? '0 : row;
    col_base  = start ? '0 : col;
    full_base = start ? 1'b0 : full;
    row_next  = row_base;
    col_next  = col_base;
    full_next = full_base;
    if (pix_valid) begin
      if (col_base == COL_LAST) begin
        col_next = '0;
        if (row_base == ROW_LAST) begin
          row_next  = '0;
          full_next = 1'b1;
        end else begin
          row_next = row_base + RW'(1);
        end
      end else begin
        col_next = col_base + CW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    set_short  = 1'b0;
    do_flip    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (valid && sot) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (eot) begin
          if (full_next) begin
            state_next = ST_WAIT_FLIP;
          end else begin
            set_short  = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      ST_WAIT_FLIP: begin
        if (frame_complete) begin
          do_flip    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      row         <= '0;
      col         <= '0;
      full        <= 1'b0;
      wen         <= 1'b0;
      wrow        <= '0;
      wcol        <= '0;
      wdata       <= '0;
      flip        <= 1'b0;
      frame_done  <= 1'b0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state      <= state_next;
      row        <= row_next;
      col        <= col_next;
      full       <= full_next;
      wen        <= pix_valid;
      frame_done <= do_flip;
      if (pix_valid) begin
        wrow  <= row_base;
        wcol  <= col_base;
        wdata <= pix;
      end
      if (do_flip) flip <= ~flip;
      if (clr_flags) begin
        err_short   <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (set_short) err_short <= 1'b1;
      if (set_over) err_overrun <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_loader.sv
module tb_frame_loader;
  import display_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [23:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] data;
  logic valid, sot, eot, frame_complete;
  logic wen, flip, busy, frame_done, err_short, err_overrun;
  logic [2:0] wrow;
  logic [4:0] wcol;
  logic [23:0] wdata;

  logic [7:0] r_data;
  logic r_valid, r_sot, r_eot, r_fc;
  logic r_wen, r_flip, r_busy, r_frame_done, r_err_short, r_err_overrun;
  logic [1:0] r_wrow, r_wcol;
  logic [23:0] r_wdata;

  frame_loader dut (
    .clk(clk), .rst(rst), .data(data), .valid(valid), .sot(sot), .eot(eot),
    .frame_complete(frame_complete), .wen(wen), .wrow(wrow), .wcol(wcol),
    .wdata(wdata), .flip(flip), .busy(busy), .frame_done(frame_done),
    .err_short(err_short), .err_overrun(err_overrun)
  );

  frame_loader #(
    .rows(4), .columns(4), .width(24), .bytes_per_pixel(3), .format(FMT_RAW)
  ) dut_raw (
    .clk(clk), .rst(rst), .data(r_data), .valid(r_valid), .sot(r_sot), .eot(r_eot),
    .frame_complete(r_fc), .wen(r_wen), .wrow(r_wrow), .wcol(r_wcol),
    .wdata(r_wdata), .flip(r_flip), .busy(r_busy), .frame_done(r_frame_done),
    .err_short(r_err_short), .err_overrun(r_err_overrun)
  );

  int total = 0;
  int bad = 0;
  wr_t cap_a[$], cap_r[$], exp_a[$], exp_r[$];

  always @(negedge clk) begin
    if (wen === 1'b1) cap_a.push_back(wr_t'({8'(wrow), 8'(wcol), wdata}));
    if (r_wen === 1'b1) cap_r.push_back(wr_t'({8'(r_wrow), 8'(r_wcol), r_wdata}));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit s, input bit e,
                       input logic [7:0] b, input bit fc);
    @(negedge clk);
    data = 8'h00; valid = 1'b0; sot = 1'b0; eot = 1'b0; frame_complete = 1'b0;
    r_data = 8'h00; r_valid = 1'b0; r_sot = 1'b0; r_eot = 1'b0; r_fc = 1'b0;
    if (sel) begin
      r_data = b; r_valid = v; r_sot = s; r_eot = e; r_fc = fc;
    end else begin
      data = b; valid = v; sot = s; eot = e; frame_complete = fc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // sot on the first byte; eot either with the last byte or one cycle later.
  task automatic send_frame(input bit sel, input byte_q_t b, input bit with_eot,
                            input bit eot_on_last, input bit fc_on_eot);
    for (int i = 0; i < b.size(); i++) begin
      drive(sel, 1'b1, i == 0,
            with_eot && eot_on_last && (i == b.size() - 1), b[i],
            fc_on_eot && with_eot && eot_on_last && (i == b.size() - 1));
    end
    if (with_eot && !eot_on_last) drive(sel, 1'b0, 1'b0, 1'b1, 8'h00, fc_on_eot);
    drive(sel, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic byte_q_t rand_bytes(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference: a frame's bytes map to whole pixels in row-major order, capped
  // at rows*columns; leftovers never produce a write.
  task automatic model_add(input byte_q_t b, input bit raw);
    int unsigned bpp, nr, nc, npix, w, r, g, bl, d;
    bpp = raw ? 3 : 2;
    nr = raw ? 4 : 8;
    nc = raw ? 4 : 32;
    npix = b.size() / bpp;
    if (npix > nr * nc) npix = nr * nc;
    for (int unsigned p = 0; p < npix; p++) begin
      if (raw) begin
        d = int'(b[3*p]) * 65536 + int'(b[3*p+1]) * 256 + int'(b[3*p+2]);
        exp_r.push_back(wr_t'({8'(p / nc), 8'(p % nc), 24'(d)}));
      end else begin
        w = int'(b[2*p]) * 256 + int'(b[2*p+1]);
        r = w / 2048;
        g = (w / 32) % 64;
        bl = w % 32;
        d = (bl * 8 + bl / 4) * 65536 + (g * 4 + g / 16) * 256 + (r * 8 + r / 4);
        exp_a.push_back(wr_t'({8'(p / nc), 8'(p % nc), 24'(d)}));
      end
    end
  endtask

  task automatic compare_writes(input string tag, input bit sel);
    wr_t c[$], e[$];
    if (sel) begin
      c = cap_r; e = exp_r; cap_r.delete(); exp_r.delete();
    end else begin
      c = cap_a; e = exp_a; cap_a.delete(); exp_a.delete();
    end
    check({tag, "_count"}, 64'(c.size()), 64'(e.size()));
    for (int i = 0; i < c.size() && i < e.size(); i++)
      check({tag, "_write"}, 64'(c[i]), 64'(e[i]));
  endtask

  initial begin
    byte_q_t q, q2;
    rst = 1'b0;
    data = 8'h00; valid = 1'b0; sot = 1'b0; eot = 1'b0; frame_complete = 1'b0;
    r_data = 8'h00; r_valid = 1'b0; r_sot = 1'b0; r_eot = 1'b0; r_fc = 1'b0;
    idle(3);
    check("rst_wen", 64'(wen), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_flip", 64'(flip), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_err", 64'({err_short, err_overrun}), 64'(0));
    check("rst_raw_busy", 64'(r_busy), 64'(0));
    rst = 1'b1;
    idle(1);

    // bytes without sot in IDLE are dropped
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    idle(2);
    check("idle_drop_busy", 64'(busy), 64'(0));
    check("idle_drop_writes", 64'(cap_a.size()), 64'(0));

    // full frame of pure red
    q.delete();
    for (int i = 0; i < 256; i++) begin q.push_back(8'hF8); q.push_back(8'h00); end
    model_add(q, 1'b0);
    send_frame(1'b0, q, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("full_last", 64'(cap_a[$]), 64'({8'd7, 8'd31, 24'h0000FF}));
    compare_writes("full", 1'b0);
    check("full_wait_busy", 64'(busy), 64'(1));
    check("full_wait_flip", 64'(flip), 64'(0));
    send_frame(1'b0, rand_bytes(6), 1'b0, 1'b0, 1'b0);
    idle(3);
    check("wait_ignore_writes", 64'(cap_a.size()), 64'(0));
    check("wait_ignore_busy", 64'(busy), 64'(1));
    check("wait_ignore_err", 64'({err_short, err_overrun}), 64'(0));
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("full_flip", 64'(flip), 64'(1));
    check("full_frame_done", 64'(frame_done), 64'(1));
    check("full_busy_fall", 64'(busy), 64'(0));
    idle(1);
    check("full_frame_done_pulse", 64'(frame_done), 64'(0));

    // short frame
    q = rand_bytes(100);
    model_add(q, 1'b0);
    send_frame(1'b0, q, 1'b1, 1'b0, 1'b0);
    check("short_err", 64'(err_short), 64'(1));
    check("short_busy", 64'(busy), 64'(0));
    check("short_flip", 64'(flip), 64'(1));
    idle(1);
    compare_writes("short", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("short_no_flip", 64'({flip, frame_done}), 64'(2'b10));

    // overrun
    q = rand_bytes(514);
    model_add(q, 1'b0);
    send_frame(1'b0, q, 1'b1, 1'b0, 1'b0);
    check("over_err", 64'({err_short, err_overrun}), 64'(2'b01));
    check("over_busy", 64'(busy), 64'(1));
    idle(1);
    compare_writes("over", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("over_flip", 64'({flip, frame_done, err_overrun}), 64'(3'b011));

    // mid-frame restart, then frame_complete coincident with the final eot
    q = rand_bytes(7);
    q2 = rand_bytes(512);
    model_add(q, 1'b0);
    model_add(q2, 1'b0);
    send_frame(1'b0, q, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, q2, 1'b1, 1'b1, 1'b1);
    check("restart_busy", 64'(busy), 64'(1));
    check("restart_no_flip", 64'({flip, frame_done}), 64'(0));
    check("restart_err", 64'({err_short, err_overrun}), 64'(0));
    idle(1);
    compare_writes("restart", 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("restart_flip", 64'({flip, frame_done}), 64'(2'b11));

    // reset while waiting for flip
    q = rand_bytes(512);
    model_add(q, 1'b0);
    send_frame(1'b0, q, 1'b1, 1'b0, 1'b0);
    idle(1);
    compare_writes("prereset", 1'b0);
    check("prereset_busy", 64'(busy), 64'(1));
    rst = 1'b0;
    idle(1);
    check("wait_rst_outputs", 64'({flip, busy, frame_done, wen}), 64'(0));
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("wait_rst_no_flip", 64'({flip, frame_done, busy}), 64'(0));

    // raw format, 3 bytes per pixel, 4x4
    q.delete();
    for (int i = 1; i <= 48; i++) q.push_back(8'(i));
    model_add(q, 1'b1);
    send_frame(1'b1, q, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("raw_busy", 64'(r_busy), 64'(1));
    check("raw_first", 64'(cap_r[0]), 64'({8'd0, 8'd0, 24'h010203}));
    check("raw_last", 64'(cap_r[$]), 64'({8'd3, 8'd3, 24'h2E2F30}));
    compare_writes("raw", 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    idle(1);
    check("raw_flip", 64'({r_flip, r_frame_done}), 64'(2'b11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
